// File: rtl/mux4_scan_pkg.sv
// Purpose : shared types and constants for the 4:1 mux scan controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, last-channel index, settle counter width.
package mux4_scan_pkg;

  // ST_ prefix keeps the state names clear of the SETTLE parameter.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CH_LAST = 2'd3;
  localparam int         CNT_W   = 4;

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Purpose : signal bundle between the scan controller and its surroundings.
// Latency : n/a (wiring only).
// Backpressure: none; start is a request level sampled only while idle.
//
// Ports (slave = controller side):
//   start, cont_en, mux_in             -> controller
//   s0, s1, data_out, valid, busy      <- controller
interface mux4_scan_ctrl_if;
  logic       start;
  logic       cont_en;
  logic       mux_in;
  logic       s0;
  logic       s1;
  logic [3:0] data_out;
  logic       valid;
  logic       busy;

  modport master (
    output start, cont_en, mux_in,
    input  s0, s1, data_out, valid, busy
  );

  modport slave (
    input  start, cont_en, mux_in,
    output s0, s1, data_out, valid, busy
  );
endinterface

// File: rtl/mux4_scan_ctrl_settle_timer.sv
// Purpose : per-channel settle counter with synchronous clear and terminal flag.
// Latency : term is combinational from the count register (cnt == SETTLE-1).
// Backpressure: none; counts whenever en is high and clr is low.
//
// Ports: clk, rst_n (async active-low), clr, en -> term.
module settle_timer
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Purpose : round-robin select driver and capture stage for a 4:1 mux.
// Latency : one word every 4*(SETTLE+1) cycles after an accepted start.
// Backpressure: none; start while busy is dropped, cont_en chains scans.
//
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   start/cont_en/mux_in in; s1:s0 select, data_out word, valid strobe, busy out.
//   All outputs are registered.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int INVERT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_scan_ctrl_if.slave   bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux4_scan_ctrl: SETTLE must be in 1..15");
  end

  // Undo the mux's output inversion so data_out bit k equals input dk.
  localparam logic INV_BIT = (INVERT != 0);

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [2:0] shadow, shadow_nxt;
  logic [3:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic       busy_q, busy_nxt;
  logic       tmr_clr, tmr_en, tmr_term;
  logic       bit_s;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 2'd0;
      shadow  <= 3'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sel     <= sel_nxt;
      shadow  <= shadow_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    shadow_nxt = shadow;
    data_nxt   = data_q;
    valid_nxt  = 1'b0;
    busy_nxt   = busy_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    bit_s      = bus.mux_in ^ INV_BIT;

    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (bus.start) begin
          state_nxt = ST_SETTLE;
          sel_nxt   = 2'd0;
          busy_nxt  = 1'b1;
        end
      end

      ST_SETTLE: begin
        // mux_in is deliberately ignored here; only the SAMPLE edge reads it.
        tmr_en = 1'b1;
        if (tmr_term) begin
          state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (sel != CH_LAST) begin
          shadow_nxt[sel] = bit_s;
          sel_nxt         = sel + 2'd1;
          tmr_clr         = 1'b1;
          state_nxt       = ST_SETTLE;
        end else begin
          // Whole word lands at once so data_out is never partially updated.
          data_nxt  = {bit_s, shadow};
          valid_nxt = 1'b1;
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        tmr_clr = 1'b1;
        sel_nxt = 2'd0;
        if (bus.cont_en) begin
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s0       = sel[0];
  assign bus.s1       = sel[1];
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Purpose : self-checking bench for mux4_scan_ctrl in three parameter sets.
// Latency : n/a.
// Backpressure: n/a.
//
// Dut 0: SETTLE=2, INVERT=1 with an inverting mux model.
// Dut 1: SETTLE=1, INVERT=0 with a non-inverting mux model.
// Dut 2: SETTLE=15, INVERT=1 with an inverting mux model.
// The reference: a scan returns the applied d3..d0 word, valid appears
// 4*(SETTLE+1) edges after the accepting edge, and channel k is selected
// during cycles k*(SETTLE+1) .. k*(SETTLE+1)+SETTLE of the scan.
module tb_mux4_scan_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4_scan_ctrl_if if0 ();
  mux4_scan_ctrl_if if1 ();
  mux4_scan_ctrl_if if2 ();

  mux4_scan_ctrl #(.SETTLE(2),  .INVERT(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux4_scan_ctrl #(.SETTLE(1),  .INVERT(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux4_scan_ctrl #(.SETTLE(15), .INVERT(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [3:0] d      [3];
  logic       start  [3];
  logic       cont   [3];
  logic       glitch [3];
  logic       win    [3];
  logic       rnd    [3];
  logic [3:0] dout   [3];
  logic [1:0] sel_o  [3];
  logic       vld    [3];
  logic       bsy    [3];

  // Mux models: inputs d3..d0 selected by s1:s0; glitch replaces the
  // result with noise outside the sample window.
  assign if0.mux_in = (glitch[0] && !win[0]) ? rnd[0] : ~d[0][{if0.s1, if0.s0}];
  assign if1.mux_in = (glitch[1] && !win[1]) ? rnd[1] :  d[1][{if1.s1, if1.s0}];
  assign if2.mux_in = (glitch[2] && !win[2]) ? rnd[2] : ~d[2][{if2.s1, if2.s0}];

  assign if0.start = start[0];  assign if0.cont_en = cont[0];
  assign if1.start = start[1];  assign if1.cont_en = cont[1];
  assign if2.start = start[2];  assign if2.cont_en = cont[2];

  assign dout[0] = if0.data_out; assign sel_o[0] = {if0.s1, if0.s0};
  assign vld[0]  = if0.valid;    assign bsy[0]   = if0.busy;
  assign dout[1] = if1.data_out; assign sel_o[1] = {if1.s1, if1.s0};
  assign vld[1]  = if1.valid;    assign bsy[1]   = if1.busy;
  assign dout[2] = if2.data_out; assign sel_o[2] = {if2.s1, if2.s0};
  assign vld[2]  = if2.valid;    assign bsy[2]   = if2.busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One scan on dut k from idle; checks select schedule, valid timing,
  // captured word and the return to idle. poke re-pulses start mid-scan.
  task automatic do_scan(input int k, input int s, input logic [3:0] dv,
                         input logic [3:0] exp, input logic gl, input logic poke);
    int per;
    per = 4 * (s + 1);
    @(negedge clk);
    d[k]      = dv;
    glitch[k] = gl;
    win[k]    = 1'b0;
    start[k]  = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int c = 0; c <= per + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c < per) begin
        chk($sformatf("sel_d%0d_c%0d", k, c), 32'(sel_o[k]), 32'(c / (s + 1)));
        chk($sformatf("valid_lo_d%0d_c%0d", k, c), 32'(vld[k]), 32'd0);
        chk($sformatf("busy_d%0d_c%0d", k, c), 32'(bsy[k]), 32'd1);
      end else if (c == per) begin
        chk($sformatf("valid_hi_d%0d", k), 32'(vld[k]), 32'd1);
        chk($sformatf("data_d%0d", k), 32'(dout[k]), 32'(exp));
        chk($sformatf("busy_done_d%0d", k), 32'(bsy[k]), 32'd1);
      end else begin
        chk($sformatf("valid_end_d%0d", k), 32'(vld[k]), 32'd0);
        chk($sformatf("busy_end_d%0d", k), 32'(bsy[k]), 32'd0);
        chk($sformatf("sel_end_d%0d", k), 32'(sel_o[k]), 32'd0);
        chk($sformatf("data_hold_d%0d", k), 32'(dout[k]), 32'(exp));
      end
      win[k]   = ((c % (s + 1)) == s);
      rnd[k]   = 1'($urandom_range(0, 1));
      start[k] = poke && (c == 3 || c == 7);
    end
    glitch[k] = 1'b0;
    win[k]    = 1'b0;
    start[k]  = 1'b0;
  endtask

  typedef struct {
    int         k;
    int         s;
    logic [3:0] dv;
    logic       gl;
    logic       poke;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc;
    logic [3:0] rv;

    for (int i = 0; i < 3; i++) begin
      d[i] = 4'd0; start[i] = 1'b0; cont[i] = 1'b0;
      glitch[i] = 1'b0; win[i] = 1'b0; rnd[i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_data_d%0d", i),  32'(dout[i]),  32'd0);
      chk($sformatf("rst_sel_d%0d", i),   32'(sel_o[i]), 32'd0);
      chk($sformatf("rst_valid_d%0d", i), 32'(vld[i]),   32'd0);
      chk($sformatf("rst_busy_d%0d", i),  32'(bsy[i]),   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sel_d0", 32'(sel_o[0]), 32'd0);
    chk("idle_busy_d0", 32'(bsy[0]), 32'd0);

    vecs[0] = '{k: 0, s: 2,  dv: 4'b1010, gl: 1'b0, poke: 1'b0, exp: 4'b1010};
    vecs[1] = '{k: 0, s: 2,  dv: 4'b1100, gl: 1'b1, poke: 1'b0, exp: 4'b1100};
    vecs[2] = '{k: 0, s: 2,  dv: 4'b0101, gl: 1'b0, poke: 1'b1, exp: 4'b0101};
    vecs[3] = '{k: 1, s: 1,  dv: 4'b1111, gl: 1'b0, poke: 1'b0, exp: 4'b1111};
    vecs[4] = '{k: 1, s: 1,  dv: 4'b0010, gl: 1'b1, poke: 1'b1, exp: 4'b0010};
    vecs[5] = '{k: 2, s: 15, dv: 4'b1001, gl: 1'b1, poke: 1'b1, exp: 4'b1001};

    for (int i = 0; i < 6; i++) begin
      do_scan(vecs[i].k, vecs[i].s, vecs[i].dv, vecs[i].exp, vecs[i].gl, vecs[i].poke);
    end

    // Randomised scans with noise during settle, against the word model.
    for (int i = 0; i < 6; i++) begin
      rv = 4'($urandom_range(0, 15));
      do_scan(0, 2, rv, rv, 1'b1, 1'($urandom_range(0, 1)));
      rv = 4'($urandom_range(0, 15));
      do_scan(1, 1, rv, rv, 1'b1, 1'b0);
    end

    // Continuous mode: back-to-back scans 13 cycles apart, no idle gap.
    @(negedge clk);
    d[0] = 4'b0110; cont[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (!vld[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("cont_first_edge", 32'(cyc), 32'd12);
    chk("cont_first_data", 32'(dout[0]), 32'b0110);
    d[0] = 4'b1001;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("cont_no_gap_busy", 32'(bsy[0]), 32'd1);
        chk("cont_no_gap_valid", 32'(vld[0]), 32'd0);
        cont[0] = 1'b0;
      end
    end while (!vld[0] && cyc < 40);
    chk("cont_period", 32'(cyc), 32'd13);
    chk("cont_second_data", 32'(dout[0]), 32'b1001);
    @(negedge clk);
    chk("cont_stop_busy", 32'(bsy[0]), 32'd0);
    chk("cont_stop_sel", 32'(sel_o[0]), 32'd0);

    // Reset in the middle of a scan, between clock edges.
    @(negedge clk);
    d[0] = 4'b0111; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(dout[0]), 32'd0);
    chk("midrst_sel", 32'(sel_o[0]), 32'd0);
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    chk("midrst_valid", 32'(vld[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld[0] || bsy[0]) cyc++;
    end
    chk("midrst_no_valid", 32'(cyc), 32'd0);
    do_scan(0, 2, 4'b0011, 4'b0011, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
